// File: rtl/matrix_word_loader_pkg.sv
// ============================================================================
// Package : matrix_pkg
// Purpose : Shared constants, FSM state type and sizing helpers for the
//           matrix word loader and its index counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int DEF_ROWS  = 6;
  localparam int DEF_COLS  = 6;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Number of elements in a ROWS x COLS matrix
  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_word_loader_if.sv
// ============================================================================
// Interface: matrix_word_loader_if
// Purpose  : Producer-side word handshake plus consumer-side matrix handshake
//            of the matrix word loader. The loader uses the slave modport;
//            the producer/consumer environment uses the master modport.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_word_loader_if
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH
);

  localparam int BUS_W = ROWS * COLS * WIDTH;

  logic [WIDTH-1:0] in_data;
  logic             in_stb;
  logic             in_last;
  logic             in_ack;
  logic [0:BUS_W-1] matrix_out;
  logic             out_stb;
  logic             out_ack;
  logic             err;

  modport slave (
    input  in_data, in_stb, in_last, out_ack,
    output in_ack, matrix_out, out_stb, err
  );

  modport master (
    output in_data, in_stb, in_last, out_ack,
    input  in_ack, matrix_out, out_stb, err
  );

endinterface

`default_nettype wire

// File: rtl/matrix_word_loader_counter.sv
// ============================================================================
// Module  : matrix_index_counter
// Purpose : Row/column slot counters with wrap. Produces the linear element
//           index row*COLS+col and a flag for the final slot of a frame.
//           MATRIX_LOADER_TRANSPOSE_EN defined : row advances first
//           (column-major input order).
//           MATRIX_LOADER_TRANSPOSE_EN undefined: column advances first
//           (row-major input order).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int IDX_W = cnt_width(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,     // asynchronous, active-low
  input  logic             clr_i,   // synchronous clear, wins over advance
  input  logic             adv_i,   // step to the next slot
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          row_end;
  logic          col_end;

  assign row_end = (row_q == RW'(ROWS - 1));
  assign col_end = (col_q == CW'(COLS - 1));

`ifdef MATRIX_LOADER_TRANSPOSE_EN
  // Column-major walk: row wraps at ROWS, then the column steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (row_end) begin
        row_q <= '0;
        col_q <= col_end ? '0 : col_q + CW'(1);
      end else begin
        row_q <= row_q + RW'(1);
      end
    end
  end
`else
  // Row-major walk: column wraps at COLS, then the row steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end
`endif

  // The final slot is row ROWS-1, column COLS-1 in either walk order
  assign idx_o  = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign last_o = row_end & col_end;

endmodule

`default_nettype wire

// File: rtl/matrix_word_loader.sv
// ============================================================================
// Module  : matrix_word_loader
// Purpose : Serial-to-parallel operand loader. Collects ROWS*COLS words, one
//           per in_stb/in_ack handshake, then holds the flattened matrix on
//           out_stb until out_ack. Pulses err on a frame length mismatch.
//           MATRIX_LOADER_TRANSPOSE_EN selects column-major input order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_word_loader
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active-low
  matrix_word_loader_if.slave  bus
);

  localparam int N     = elem_count(ROWS, COLS);
  localparam int IDX_W = cnt_width(N);
  localparam int BUS_W = N * WIDTH;

  state_t           state_q;
  logic             in_ack_q;
  logic             out_stb_q;
  logic             err_q;
  logic [0:BUS_W-1] matrix_q;

  logic             xfer;
  logic             short_frame;
  logic [IDX_W-1:0] idx;
  logic             last;

  // in_ack_q is only ever high in FILL, so it alone qualifies a transfer
  assign xfer        = bus.in_stb & in_ack_q;
  assign short_frame = xfer & bus.in_last & ~last;

  matrix_index_counter #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_index (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (short_frame),
    .adv_i  (xfer),
    .idx_o  (idx),
    .last_o (last)
  );

  // Frame FSM with registered handshake outputs and one-cycle err pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (xfer && last) begin
            state_q   <= PRESENT;
            in_ack_q  <= 1'b0;
            out_stb_q <= 1'b1;
            err_q     <= ~bus.in_last;
          end else begin
            // Also raises in_ack on the first edge after reset release
            in_ack_q <= 1'b1;
            if (short_frame) begin
              err_q <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (out_stb_q && bus.out_ack) begin
            state_q   <= FILL;
            in_ack_q  <= 1'b1;
            out_stb_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= FILL;
          in_ack_q  <= 1'b0;
          out_stb_q <= 1'b0;
        end
      endcase
    end
  end

  // Element storage: the accepted word lands in the slot the counter points at
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrix_q <= '0;
    end else if (xfer) begin
      for (int e = 0; e < N; e++) begin
        if (idx == IDX_W'(e)) begin
          matrix_q[e*WIDTH +: WIDTH] <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ack     = in_ack_q;
  assign bus.out_stb    = out_stb_q;
  assign bus.err        = err_q;
  assign bus.matrix_out = matrix_q;

endmodule

`default_nettype wire

// File: doc/matrix_word_loader.md
# matrix_word_loader

Serial-to-parallel loader upstream of `matrix_multiplier`. Accepts one IEEE-754 single-precision element per handshake and assembles a flattened ROWS×COLS operand bus. When the matrix is complete, presents it on the multiplier's `a_stb`/`a_ack` (or `b_stb`/`b_ack`) port. One instance per operand; the bus holds steady until the multiplier acknowledges.

## Interface
- `ROWS`, default 6: matrix rows.
- `COLS`, default 6: matrix columns.
- `WIDTH`, default 32: element width in bits.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `in_data` input, WIDTH bits: element word.
- `in_stb` input, 1 bit: producer has a valid word.
- `in_last` input, 1 bit: marks the producer's final word of the frame.
- `in_ack` output, 1 bit: registered; loader can accept a word.
- `matrix_out` output, bits [0:ROWS*COLS*WIDTH-1]: flattened matrix; element e occupies `[e*WIDTH +: WIDTH]`, e = row*COLS+col.
- `out_stb` output, 1 bit: registered; matrix valid.
- `out_ack` input, 1 bit: consumer accepted the matrix.
- `err` output, 1 bit: registered one-cycle pulse on frame length mismatch.

## Operation
- N = ROWS*COLS. The state machine has two states: FILL and PRESENT.
- **Reset (rst=0):**
  - state FILL, slot counter 0.
  - `in_ack`=0, `out_stb`=0, `err`=0, `matrix_out`=all zeros.
  - First rising edge after release sets `in_ack`=1.
- **Input transfer:** occurs on a rising edge with `in_stb`=1 and `in_ack`=1.
  - The word is written to its slot and the counter advances.
  - `in_ack` without `in_stb`, or `in_stb` without `in_ack`, transfers nothing.
- **Slot order (default):** row-major, so word k goes to element k.
- **FILL → PRESENT:** on transfer of word N-1.
  - `in_ack`←0 and `out_stb`←1 at that same edge.
  - Counter wraps to 0.
- **PRESENT:**
  - `matrix_out` is frozen and `in_ack` stays 0.
  - A rising edge with `out_stb`=1 and `out_ack`=1 sets `out_stb`←0 and `in_ack`←1, and returns to FILL.
  - `out_ack` while in FILL is ignored.
- **Length check:**
  - `in_last`=1 on a transfer with counter < N-1: that word is written, `err` pulses, counter resets to 0, state stays FILL. The partial frame is discarded; earlier slot contents are stale until overwritten.
  - `in_last`=0 on the word N-1 transfer: the matrix is still presented and `err` pulses.
- **Mid-operation reset:** the asynchronous clear wins in every state. Any partial or presented matrix is lost, and `out_stb` drops immediately.
- Elements are passed bit-exact. No arithmetic is performed on data.

## Timing
- Fill throughput: one word per cycle while `in_stb` is held high.
- Latency: `out_stb` is high in the cycle after the edge accepting word N-1.
- Minimum frame period: N+1 cycles, when `out_ack` is tied high.
- `in_ack` and `out_stb` are never both 1.
- `matrix_out` changes only on input transfer edges in FILL.

## Configuration
- `MATRIX_LOADER_TRANSPOSE_EN` defined: input is column-major. Word k goes to element (k mod ROWS)*COLS + (k div ROWS), computed with separate row/col counters (row increments first, wraps at ROWS, then col increments). Used for the B operand when the producer emits columns.
- Undefined: row-major only; col counter increments first and wraps at COLS.
- The handshake, latency and error behaviour are identical in both builds.

## Structure
- Shared package `matrix_pkg`:
  - default ROWS/COLS/WIDTH constants.
  - state typedef (FILL, PRESENT).
  - element-count function ROWS*COLS.
- One sub-module, `matrix_index_counter`:
  - holds the row/col counters with wrap.
  - provides a linear slot index output, a `last` flag (slot N-1), and a synchronous clear.
  - transpose ordering is selected by the macro.

## Test plan
- **Reset:** hold rst=0 for 3 cycles, release → `in_ack`=0 in the first cycle, 1 after the next edge; `out_stb`=0; `matrix_out`=0.
- **Full frame row-major:** stream 36 words 0x3F800000+k with `in_stb` high and `in_last` on k=35 → `out_stb`=1 one cycle after word 35. Element 7 reads 0x3F800007. `in_ack`=0 until `out_ack`.
- **Backpressure:** hold `out_ack`=0 for 10 cycles → `matrix_out` unchanged and `in_stb` words not accepted. Pulse `out_ack` → `out_stb`=0 and `in_ack`=1 next cycle.
- **Short frame:** `in_last` on word 20 → `err` pulses one cycle, no `out_stb`. The next 36 words present normally.
- **Transpose build:** with `MATRIX_LOADER_TRANSPOSE_EN`, word k=1 value 0xAAAA0001 → lands at element 6. Word 6 → element 1.
- **Mid-frame reset:** rst=0 after word 17 → `out_stb`/`in_ack` go 0 immediately. A subsequent full frame presents the correct contents.
